mem_arbiter2: RTL and testbench

//   Two-master arbiter sharing the single 32-bit mem_* port of sram16_ctrl.

---
 rtl/mem_arbiter2_if.sv | 26 ++
 rtl/mem_arbiter2.sv | 119 +++++++++++
 tb/tb_mem_arbiter2.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter2_if.sv
// Memory command/return bundle shared by the two masters and the sram16_ctrl slave port.
// The master side drives commands; the slave side stalls and returns id-tagged read data.
interface mem_arbiter2_if #(
    parameter int unsigned ADDR_W = 30,
    parameter int unsigned ID_W   = 2
);
    logic              waitrequest;
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [3:0]        writedatamask;
    logic [31:0]       readdata;
    logic [ID_W-1:0]   readdataid;

    modport master (
        input  waitrequest, readdata, readdataid,
        output id, address, read, write, writedata, writedatamask
    );

    modport slave (
        output waitrequest, readdata, readdataid,
        input  id, address, read, write, writedata, writedatamask
    );
endinterface

// File: rtl/mem_arbiter2.sv
// Two-master round-robin arbiter in front of one memory port; read returns are routed
// back to the issuing master through an in-order owner FIFO.
module mem_arbiter2 #(
    parameter int unsigned FIFO_LOG2 = 3
) (
    input  logic                 clock,
    input  logic                 rst,
    mem_arbiter2_if.slave        m0,
    mem_arbiter2_if.slave        m1,
    mem_arbiter2_if.master       s,
    output logic                 protocol_err
);
    localparam int unsigned Depth = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2:0] FullCount = (FIFO_LOG2 + 1)'(Depth);

    logic                 lock_q, lock_d;
    logic                 owner_q, owner_d;
    logic                 last_q, last_d;
    logic [FIFO_LOG2-1:0] rd_ptr_q, wr_ptr_q;
    logic [FIFO_LOG2:0]   count_q, count_d;
    logic [Depth-1:0]     owner_fifo_q;
    logic                 perr_q;

    logic req0, req1, sel, sel_read, sel_write;
    logic fifo_full, fifo_empty, accept, push, pop, ret_valid, head;

    assign req0       = m0.read | m0.write;
    assign req1       = m1.read | m1.write;
    assign fifo_full  = (count_q == FullCount);
    assign fifo_empty = (count_q == '0);

    // A stalled command keeps the grant until it is accepted.
    always_comb begin
        sel = 1'b0;
        if (lock_q) begin
            sel = owner_q;
        end else if (req0 && req1) begin
            sel = ~last_q;
        end else begin
            sel = req1;
        end
    end

    assign sel_read  = sel ? m1.read  : m0.read;
    assign sel_write = sel ? m1.write : m0.write;

    always_comb begin
        s.id            = sel ? m1.id            : m0.id;
        s.address       = sel ? m1.address       : m0.address;
        s.writedata     = sel ? m1.writedata     : m0.writedata;
        s.writedatamask = sel ? m1.writedatamask : m0.writedatamask;
        // Reads wait on a full owner FIFO; writes never do.
        s.read          = sel_read & ~fifo_full & ~rst;
        s.write         = sel_write & ~rst;
    end

    assign accept = (s.read | s.write) & ~s.waitrequest;

    assign m0.waitrequest = ~(accept & ~sel);
    assign m1.waitrequest = ~(accept & sel);

    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        last_d  = last_q;
        if (accept) begin
            lock_d = 1'b0;
            last_d = sel;
        end else if (sel_read | sel_write) begin
            lock_d  = 1'b1;
            owner_d = sel;
        end
    end

    assign push      = accept & s.read;
    assign ret_valid = (s.readdataid != '0);
    assign pop       = ret_valid & ~fifo_empty;
    assign head      = owner_fifo_q[rd_ptr_q];

    assign m0.readdata   = s.readdata;
    assign m1.readdata   = s.readdata;
    assign m0.readdataid = (pop && !head) ? s.readdataid : '0;
    assign m1.readdataid = (pop && head)  ? s.readdataid : '0;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            lock_q   <= 1'b0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            perr_q   <= 1'b0;
        end else begin
            lock_q  <= lock_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (ret_valid && fifo_empty) perr_q <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) owner_fifo_q[wr_ptr_q] <= sel;
    end

    assign protocol_err = perr_q;
endmodule

// File: tb/tb_mem_arbiter2.sv
// Directed bench for mem_arbiter2: a queue-based reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_mem_arbiter2;
    logic clock = 1'b0;
    logic rst   = 1'b1;
    logic protocol_err;

    int checks = 0;
    int errors = 0;

    mem_arbiter2_if #(.ADDR_W(30), .ID_W(2)) m0_bus ();
    mem_arbiter2_if #(.ADDR_W(30), .ID_W(2)) m1_bus ();
    mem_arbiter2_if #(.ADDR_W(30), .ID_W(2)) s_bus ();

    mem_arbiter2 #(.FIFO_LOG2(3)) dut (
        .clock        (clock),
        .rst          (rst),
        .m0           (m0_bus.slave),
        .m1           (m1_bus.slave),
        .s            (s_bus.master),
        .protocol_err (protocol_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who holds the grant, who was served last, owners of pending reads.
    int mdl_held = -1;
    int mdl_last = 1;
    int mdl_q[$];
    bit mdl_err = 1'b0;

    bit          rd[2], wr[2];
    logic [29:0] ad[2];
    logic [1:0]  idv[2];
    int          msel;
    bit          e_read, e_write, e_acc;
    logic [1:0]  e_rid[2];

    always @(negedge clock) begin
        if (rst) begin
            chk("rst_m0_wait", m0_bus.waitrequest, 1);
            chk("rst_m1_wait", m1_bus.waitrequest, 1);
            chk("rst_perr", protocol_err, 0);
            mdl_held = -1;
            mdl_last = 1;
            mdl_q.delete();
            mdl_err  = 1'b0;
        end else begin
            rd[0] = m0_bus.read;  wr[0] = m0_bus.write;
            rd[1] = m1_bus.read;  wr[1] = m1_bus.write;
            ad[0] = m0_bus.address; ad[1] = m1_bus.address;
            idv[0] = m0_bus.id;   idv[1] = m1_bus.id;
            if (mdl_held >= 0) msel = mdl_held;
            else if ((rd[0] || wr[0]) && (rd[1] || wr[1])) msel = 1 - mdl_last;
            else msel = (rd[1] || wr[1]) ? 1 : 0;
            e_read  = rd[msel] && (mdl_q.size() < 8);
            e_write = wr[msel];
            e_acc   = (e_read || e_write) && !s_bus.waitrequest;
            e_rid[0] = '0;
            e_rid[1] = '0;
            if (s_bus.readdataid != 0 && mdl_q.size() > 0)
                e_rid[mdl_q[0]] = s_bus.readdataid;

            chk("s_read", s_bus.read, e_read);
            chk("s_write", s_bus.write, e_write);
            chk("m0_wait", m0_bus.waitrequest, !(e_acc && msel == 0));
            chk("m1_wait", m1_bus.waitrequest, !(e_acc && msel == 1));
            chk("m0_rid", m0_bus.readdataid, e_rid[0]);
            chk("m1_rid", m1_bus.readdataid, e_rid[1]);
            chk("m0_rdata", m0_bus.readdata, s_bus.readdata);
            chk("m1_rdata", m1_bus.readdata, s_bus.readdata);
            chk("perr", protocol_err, mdl_err);
            if (e_read || e_write) begin
                chk("s_address", s_bus.address, ad[msel]);
                chk("s_id", s_bus.id, idv[msel]);
            end

            if (s_bus.readdataid != 0) begin
                if (mdl_q.size() > 0) void'(mdl_q.pop_front());
                else mdl_err = 1'b1;
            end
            if (e_acc) begin
                mdl_held = -1;
                mdl_last = msel;
                if (e_read) mdl_q.push_back(msel);
            end else if (rd[msel] || wr[msel]) begin
                mdl_held = msel;
            end
        end
    end

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        m0_bus.read = 0; m0_bus.write = 0;
        m1_bus.read = 0; m1_bus.write = 0;
        s_bus.waitrequest = 0;
        s_bus.readdataid  = 0;
    endtask

    task automatic drive(input int m, input bit r, input bit w, input logic [29:0] a,
                         input logic [1:0] id);
        if (m == 0) begin
            m0_bus.read = r; m0_bus.write = w; m0_bus.address = a; m0_bus.id = id;
            m0_bus.writedata = 32'hA000_0000 | 32'(a); m0_bus.writedatamask = 4'hF;
        end else begin
            m1_bus.read = r; m1_bus.write = w; m1_bus.address = a; m1_bus.id = id;
            m1_bus.writedata = 32'hB000_0000 | 32'(a); m1_bus.writedatamask = 4'h3;
        end
    endtask

    initial begin
        drive(0, 0, 0, 30'h0, 2'd0);
        drive(1, 0, 0, 30'h0, 2'd0);
        idle();
        s_bus.readdata = 32'h0;

        @(negedge clock);
        chk("reset_s_read", s_bus.read, 0);
        chk("reset_s_write", s_bus.write, 0);
        chk("reset_m0_wait", m0_bus.waitrequest, 1);
        chk("reset_m1_wait", m1_bus.waitrequest, 1);
        next();
        rst = 0;

        // Both masters write back-to-back: grants alternate starting with m0.
        drive(0, 0, 1, 30'h100, 2'd0);
        drive(1, 0, 1, 30'h200, 2'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("rr_addr", s_bus.address, (k % 2) ? 32'h200 : 32'h100);
            next();
        end
        idle();

        // Lone read, forwarded in the same cycle, return routed to m0.
        drive(0, 1, 0, 30'h10, 2'd1);
        @(negedge clock);
        chk("rd1_s_read", s_bus.read, 1);
        chk("rd1_m0_wait", m0_bus.waitrequest, 0);
        next();
        m0_bus.read = 0;
        s_bus.readdata = 32'hDEAD_BEEF;
        s_bus.readdataid = 2'd1;
        @(negedge clock);
        chk("rd1_m0_rid", m0_bus.readdataid, 1);
        chk("rd1_m1_rid", m1_bus.readdataid, 0);
        chk("rd1_m0_rdata", m0_bus.readdata, 32'hDEAD_BEEF);
        next();
        idle();

        // m1 write stalled 3 cycles holds the port against m0.
        drive(1, 0, 1, 30'h222, 2'd0);
        s_bus.waitrequest = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("stall_addr", s_bus.address, 32'h222);
            if (k > 0) chk("stall_m0_wait", m0_bus.waitrequest, 1);
            next();
            drive(0, 0, 1, 30'h111, 2'd0);
        end
        s_bus.waitrequest = 0;
        @(negedge clock);
        chk("stall_m1_acc", m1_bus.waitrequest, 0);
        next();
        m1_bus.write = 0;
        @(negedge clock);
        chk("after_stall_addr", s_bus.address, 32'h111);
        chk("after_stall_m0_wait", m0_bus.waitrequest, 0);
        next();
        idle();

        // Nine reads with no returns: the ninth waits on a full owner FIFO.
        for (int i = 0; i < 9; i++) begin
            drive(0, 1, 0, 30'h300 + 30'(i), 2'd1);
            @(negedge clock);
            chk("fill_s_read", s_bus.read, (i < 8) ? 1 : 0);
            chk("fill_m0_wait", m0_bus.waitrequest, (i < 8) ? 0 : 1);
            next();
        end
        s_bus.readdataid = 2'd1;
        @(negedge clock);
        chk("full_pop_s_read", s_bus.read, 0);
        chk("full_pop_m0_rid", m0_bus.readdataid, 1);
        next();
        s_bus.readdataid = 2'd0;
        @(negedge clock);
        chk("ninth_s_read", s_bus.read, 1);
        chk("ninth_m0_wait", m0_bus.waitrequest, 0);
        next();
        drive(0, 1, 0, 30'h309, 2'd1);
        @(negedge clock);
        chk("tenth_gated", s_bus.read, 0);
        next();
        s_bus.readdataid = 2'd1;
        @(negedge clock);
        next();
        s_bus.readdataid = 2'd0;
        @(negedge clock);
        chk("tenth_acc", s_bus.read, 1);
        next();
        m0_bus.read = 0;
        for (int i = 0; i < 8; i++) begin
            s_bus.readdataid = 2'd1;
            @(negedge clock);
            chk("drain_m0_rid", m0_bus.readdataid, 1);
            next();
        end
        idle();

        // Interleaved reads from both masters return in issue order.
        drive(0, 1, 0, 30'h40, 2'd2);
        next();
        m0_bus.read = 0;
        drive(1, 1, 0, 30'h41, 2'd3);
        next();
        m1_bus.read = 0;
        drive(0, 1, 0, 30'h42, 2'd1);
        next();
        m0_bus.read = 0;
        s_bus.readdataid = 2'd2;
        @(negedge clock);
        chk("il_ret0_m0", m0_bus.readdataid, 2);
        chk("il_ret0_m1", m1_bus.readdataid, 0);
        next();
        s_bus.readdataid = 2'd3;
        @(negedge clock);
        chk("il_ret1_m0", m0_bus.readdataid, 0);
        chk("il_ret1_m1", m1_bus.readdataid, 3);
        next();
        s_bus.readdataid = 2'd1;
        @(negedge clock);
        chk("il_ret2_m0", m0_bus.readdataid, 1);
        chk("il_ret2_m1", m1_bus.readdataid, 0);
        next();
        idle();

        // Return with nothing outstanding after reset.
        rst = 1;
        @(negedge clock);
        next();
        rst = 0;
        s_bus.readdataid = 2'd2;
        @(negedge clock);
        chk("orphan_m0_rid", m0_bus.readdataid, 0);
        chk("orphan_m1_rid", m1_bus.readdataid, 0);
        next();
        s_bus.readdataid = 2'd0;
        @(negedge clock);
        chk("orphan_perr", protocol_err, 1);
        next();

        // Reset in the middle of a stall releases the lock.
        drive(1, 0, 1, 30'h222, 2'd0);
        s_bus.waitrequest = 1;
        @(negedge clock);
        chk("pre_rst_m1_wait", m1_bus.waitrequest, 1);
        next();
        drive(0, 0, 1, 30'h111, 2'd0);
        #2 rst = 1;
        #1;
        chk("mid_rst_m0_wait", m0_bus.waitrequest, 1);
        chk("mid_rst_m1_wait", m1_bus.waitrequest, 1);
        chk("mid_rst_perr", protocol_err, 0);
        @(negedge clock);
        next();
        rst = 0;
        s_bus.waitrequest = 0;
        @(negedge clock);
        chk("post_rst_addr", s_bus.address, 32'h111);
        chk("post_rst_m0_wait", m0_bus.waitrequest, 0);
        next();
        idle();
        repeat (3) next();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
